// File: rtl/branch_pkg.sv
// Shared types and branch-function encodings for the branch resolution block.
// Optional statistics counters in branch_resolve_ctrl are enabled by BRANCH_STATS_EN.
package branch_pkg;

    localparam logic [3:0] BF_LTZ = 4'b0010;
    localparam logic [3:0] BF_GEZ = 4'b0011;
    localparam logic [3:0] BF_EQ  = 4'b0100;
    localparam logic [3:0] BF_NE  = 4'b0101;
    localparam logic [3:0] BF_LEZ = 4'b0110;
    localparam logic [3:0] BF_GTZ = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        REDIRECT
    } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: (a, b, bf) -> (taken, err).
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      bf,
    output logic            taken,
    output logic            err
);

    logic neg;
    logic zero;
    logic eq;

    assign neg  = a[XLEN-1];
    assign zero = (a == '0);
    assign eq   = (a == b);

    always_comb begin
        taken = 1'b0;
        err   = 1'b0;
        case (bf)
            BF_LTZ:  taken = neg;
            BF_GEZ:  taken = !neg;
            BF_EQ:   taken = eq;
            BF_NE:   taken = !eq;
            BF_LEZ:  taken = neg || zero;
            BF_GTZ:  taken = !neg && !zero;
            default: err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: accept, evaluate, redirect fetch on mispredict.
// Define BRANCH_STATS_EN to add saturating taken/not-taken/mispredict counters.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
`ifdef BRANCH_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [3:0]      req_bf,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_off,
    input  logic            req_pred,
    output logic            resolve_valid,
    output logic            resolve_taken,
    output logic            resolve_err,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_ntaken,
    output logic [CNT_W-1:0] stat_mispred
`endif
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, b_q, pc_q, off_q, redir_pc_q;
    logic [3:0]      bf_q;
    logic            pred_q;
    logic            taken, err, mispred, accept, eval_live;
    logic [XLEN-1:0] target;

    branch_cond_eval #(
        .XLEN(XLEN)
    ) u_cond_eval (
        .a    (a_q),
        .b    (b_q),
        .bf   (bf_q),
        .taken(taken),
        .err  (err)
    );

    assign mispred   = (taken != pred_q);
    assign accept    = req_valid && req_ready;
    assign eval_live = (state_q == EVAL) && !kill;
    // Modulo-2^XLEN arithmetic; wrap-around is intentional.
    assign target    = pc_q + XLEN'(4) + (taken ? (off_q << 2) : '0);
    assign redir_pc  = redir_pc_q;

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        resolve_err   = 1'b0;
        redir_valid   = 1'b0;
        flush         = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = !kill;
                if (req_valid && !kill) state_d = EVAL;
            end
            EVAL: begin
                resolve_valid = !kill;
                resolve_taken = taken && !kill;
                resolve_err   = err && !kill;
                state_d       = mispred ? REDIRECT : IDLE;
            end
            REDIRECT: begin
                redir_valid = !kill;
                flush       = redir_valid && redir_ready;
                if (redir_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            pc_q       <= '0;
            off_q      <= '0;
            bf_q       <= '0;
            pred_q     <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= req_a;
                b_q    <= req_b;
                pc_q   <= req_pc;
                off_q  <= req_off;
                bf_q   <= req_bf;
                pred_q <= req_pred;
            end
            if (eval_live && mispred) redir_pc_q <= target;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_q, ntaken_q, mispred_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q   <= '0;
            ntaken_q  <= '0;
            mispred_q <= '0;
        end else if (eval_live) begin
            if (taken && (taken_q != '1))      taken_q   <= taken_q + CNT_W'(1);
            if (!taken && (ntaken_q != '1))    ntaken_q  <= ntaken_q + CNT_W'(1);
            if (mispred && (mispred_q != '1))  mispred_q <= mispred_q + CNT_W'(1);
        end
    end

    assign stat_taken   = taken_q;
    assign stat_ntaken  = ntaken_q;
    assign stat_mispred = mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl (stats checks when BRANCH_STATS_EN).
module tb_branch_resolve_ctrl;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kill;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b, req_pc, req_off;
    logic [3:0]  req_bf;
    logic        req_pred;
    logic        resolve_valid, resolve_taken, resolve_err;
    logic        redir_valid, redir_ready, flush;
    logic [31:0] redir_pc;
`ifdef BRANCH_STATS_EN
    logic [3:0]  stat_taken, stat_ntaken, stat_mispred;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(
        .XLEN(32)
`ifdef BRANCH_STATS_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .kill         (kill),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_bf       (req_bf),
        .req_pc       (req_pc),
        .req_off      (req_off),
        .req_pred     (req_pred),
        .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken),
        .resolve_err  (resolve_err),
        .redir_valid  (redir_valid),
        .redir_ready  (redir_ready),
        .redir_pc     (redir_pc),
        .flush        (flush)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken   (stat_taken),
        .stat_ntaken  (stat_ntaken),
        .stat_mispred (stat_mispred)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a request on the falling edge; it is accepted on the next rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] bf,
                         input logic [31:0] pc, input logic [31:0] off, input logic pred);
        @(negedge clk);
        req_a = a; req_b = b; req_bf = bf; req_pc = pc; req_off = off; req_pred = pred;
        req_valid = 1'b1;
        #1 check("accept_ready", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    // Complete a pending redirect handshake and confirm the one-cycle flush.
    task automatic finish_redirect(input string tag);
        redir_ready = 1'b1;
        #1 check({tag, "_flush"}, flush, 1'b1);
        @(posedge clk);
        #1 redir_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, req_ready, 1'b1);
        check({tag, "_flush_gone"}, flush, 1'b0);
        check({tag, "_redir_gone"}, redir_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; kill = 1'b0; req_valid = 1'b0; redir_ready = 1'b0;
        req_a = '0; req_b = '0; req_bf = '0; req_pc = '0; req_off = '0; req_pred = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resolve_valid", resolve_valid, 1'b0);
        check("rst_resolve_taken", resolve_taken, 1'b0);
        check("rst_resolve_err", resolve_err, 1'b0);
        check("rst_redir_valid", redir_valid, 1'b0);
        check("rst_redir_pc", redir_pc, 32'h0);
        check("rst_flush", flush, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Not taken, correctly predicted
        issue(32'hFFFF_FFFF, 32'h0, 4'b0011, 32'h100, 32'h0, 1'b0);
        check("nt_resolve_valid", resolve_valid, 1'b1);
        check("nt_taken", resolve_taken, 1'b0);
        check("nt_err", resolve_err, 1'b0);
        check("nt_eval_ready", req_ready, 1'b0);
        next_cycle();
        check("nt_ready_after", req_ready, 1'b1);
        check("nt_no_redir", redir_valid, 1'b0);
        check("nt_resolve_gone", resolve_valid, 1'b0);

        // Taken mispredict
        issue(32'h1234_5678, 32'h1234_5678, 4'b0100, 32'h100, 32'd3, 1'b0);
        check("tm_resolve_valid", resolve_valid, 1'b1);
        check("tm_taken", resolve_taken, 1'b1);
        next_cycle();
        check("tm_redir_valid", redir_valid, 1'b1);
        check("tm_redir_pc", redir_pc, 32'h110);
        check("tm_no_flush_yet", flush, 1'b0);
        check("tm_busy", req_ready, 1'b0);
        finish_redirect("tm");

        // Not-taken mispredict with stalled fetch
        issue(32'h0, 32'h0, 4'b0111, 32'h200, 32'h0, 1'b1);
        check("st_taken", resolve_taken, 1'b0);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            check("st_redir_valid", redir_valid, 1'b1);
            check("st_redir_pc", redir_pc, 32'h204);
            check("st_no_flush", flush, 1'b0);
        end
        finish_redirect("st");

        // PC wrap-around
        issue(32'h0, 32'h0, 4'b0110, 32'hFFFF_FFFC, 32'd1, 1'b0);
        check("wr_taken", resolve_taken, 1'b1);
        next_cycle();
        check("wr_redir_pc", redir_pc, 32'h4);
        finish_redirect("wr");

        // Illegal function code predicted taken
        issue(32'h5, 32'h5, 4'b1111, 32'h300, 32'd8, 1'b1);
        check("il_err", resolve_err, 1'b1);
        check("il_taken", resolve_taken, 1'b0);
        next_cycle();
        check("il_redir_valid", redir_valid, 1'b1);
        check("il_redir_pc", redir_pc, 32'h304);
        finish_redirect("il");

        // Kill in IDLE blocks acceptance
        @(negedge clk);
        kill = 1'b1;
        #1 check("ki_idle_ready", req_ready, 1'b0);
        kill = 1'b0;

        // Kill during EVAL of a branch that would otherwise mispredict
        issue(32'h7, 32'h7, 4'b0100, 32'h400, 32'd1, 1'b0);
        kill = 1'b1;
        #1 check("ke_resolve_valid", resolve_valid, 1'b0);
        check("ke_resolve_taken", resolve_taken, 1'b0);
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("ke_idle_ready", req_ready, 1'b1);
        check("ke_no_redir", redir_valid, 1'b0);

        // Kill during REDIRECT together with redir_ready
        issue(32'h7, 32'h8, 4'b0100, 32'h500, 32'd1, 1'b1);
        next_cycle();
        check("kr_redir_valid", redir_valid, 1'b1);
        check("kr_redir_pc", redir_pc, 32'h504);
        kill = 1'b1;
        redir_ready = 1'b1;
        #1 check("kr_no_flush", flush, 1'b0);
        check("kr_redir_suppressed", redir_valid, 1'b0);
        @(posedge clk);
        #1 kill = 1'b0;
        redir_ready = 1'b0;
        @(negedge clk);
        check("kr_idle_ready", req_ready, 1'b1);
        check("kr_redir_gone", redir_valid, 1'b0);

        // Asynchronous reset while in REDIRECT
        issue(32'h1, 32'h2, 4'b0101, 32'h600, 32'd2, 1'b0);
        next_cycle();
        check("ar_redir_valid", redir_valid, 1'b1);
        rst_n = 1'b0;
        #1 check("ar_redir_cleared", redir_valid, 1'b0);
        check("ar_pc_cleared", redir_pc, 32'h0);
        check("ar_ready", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BRANCH_STATS_EN
        for (int i = 0; i < 20; i++) begin
            issue(32'h0, 32'h0, 4'b0100, 32'h700, 32'd1, 1'b1);
            next_cycle();
        end
        check("sx_taken_sat", stat_taken, 4'hF);
        check("sx_ntaken", stat_ntaken, 4'h0);
        check("sx_mispred", stat_mispred, 4'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
